// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement and halt-time flush.
// Optional feature: define HIT_COUNT_EN to keep a net hit counter and store it to CNT_ADDR after the flush.
module dcache_nway #(
    parameter int          NSETS    = 8,
    parameter int          NWAYS    = 2,
    parameter int          WORDS    = 2,
    parameter logic [31:0] CNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int IDX_W = $clog2(NSETS);
    localparam int AGE_W = $clog2(NWAYS);
    localparam int BLK_W = $clog2(WORDS);
    localparam int TAG_W = 32 - IDX_W - BLK_W - 2;
    localparam int PTR_W = IDX_W + AGE_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB    = 3'd1;
    localparam logic [2:0] S_LD    = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_CNT   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

`ifdef HIT_COUNT_EN
    localparam logic [2:0] S_END = S_CNT;
`else
    localparam logic [2:0] S_END = S_DONE;
`endif

    logic [2:0]       r_state;
    logic [TAG_W-1:0] r_tag   [NSETS][NWAYS];
    logic [NWAYS-1:0] r_valid [NSETS];
    logic [NWAYS-1:0] r_dirty [NSETS];
    logic [AGE_W-1:0] r_age   [NSETS][NWAYS];
    logic [31:0]      r_data  [NSETS][NWAYS][WORDS];
    logic [IDX_W-1:0] r_idx;
    logic [AGE_W-1:0] r_way;
    logic [BLK_W-1:0] r_beat;
    logic [TAG_W-1:0] r_req_tag;
    logic [PTR_W-1:0] r_ptr;

    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [BLK_W-1:0] w_blk;
    logic             w_req;
    logic             w_is_wr;
    logic             w_hit;
    logic [AGE_W-1:0] w_hit_way;
    logic             w_has_inv;
    logic [AGE_W-1:0] w_inv_way;
    logic [AGE_W-1:0] w_lru_way;
    logic [AGE_W-1:0] w_vic;
    logic             w_idle_go;
    logic             w_hit_now;
    logic             w_miss_now;
    logic             w_last_beat;
    logic             w_fill_done;
    logic             w_last_ptr;
    logic [IDX_W-1:0] w_scan_idx;
    logic [AGE_W-1:0] w_scan_way;
    logic             w_touch;
    logic [IDX_W-1:0] w_touch_idx;
    logic [AGE_W-1:0] w_touch_way;
    logic [31:0]      w_cnt_val;
    logic             w_unused;

    assign w_tag       = dmemaddr[31:IDX_W+BLK_W+2];
    assign w_idx       = dmemaddr[IDX_W+BLK_W+1:BLK_W+2];
    assign w_blk       = dmemaddr[BLK_W+1:2];
    assign w_unused    = ^dmemaddr[1:0];
    assign w_req       = dmemREN | dmemWEN;
    assign w_is_wr     = dmemWEN & ~dmemREN;
    assign w_idle_go   = (r_state == S_IDLE) && !halt && w_req;
    assign w_hit_now   = w_idle_go && w_hit;
    assign w_miss_now  = w_idle_go && !w_hit;
    assign w_last_beat = (r_beat == BLK_W'(WORDS - 1));
    assign w_fill_done = (r_state == S_LD) && !dwait && w_last_beat;
    assign w_last_ptr  = (r_ptr == {PTR_W{1'b1}});
    assign w_scan_idx  = r_ptr[PTR_W-1:AGE_W];
    assign w_scan_way  = r_ptr[AGE_W-1:0];
    assign w_touch     = w_hit_now || w_fill_done;
    assign w_touch_idx = w_fill_done ? r_idx : w_idx;
    assign w_touch_way = w_fill_done ? r_way : w_hit_way;
    assign w_vic       = w_has_inv ? w_inv_way : w_lru_way;

    // Descending loops so the lowest-index match wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        w_lru_way = '0;
        for (int i = NWAYS - 1; i >= 0; i--) begin
            if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = AGE_W'(i);
            end
            if (!r_valid[w_idx][i]) begin
                w_has_inv = 1'b1;
                w_inv_way = AGE_W'(i);
            end
            if (r_age[w_idx][i] == AGE_W'(NWAYS - 1)) begin
                w_lru_way = AGE_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_way     <= '0;
            r_beat    <= '0;
            r_req_tag <= '0;
            r_ptr     <= '0;
            for (int s = 0; s < NSETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < NWAYS; w++) begin
                    r_tag[s][w] <= '0;
                    r_age[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            if (w_touch) begin
                for (int w = 0; w < NWAYS; w++) begin
                    if (AGE_W'(w) == w_touch_way) begin
                        r_age[w_touch_idx][w] <= '0;
                    end else if (r_age[w_touch_idx][w] < r_age[w_touch_idx][w_touch_way]) begin
                        r_age[w_touch_idx][w] <= r_age[w_touch_idx][w] + AGE_W'(1);
                    end
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (halt) begin
                        r_state <= S_SCAN;
                        r_ptr   <= '0;
                    end else if (w_req) begin
                        if (w_hit) begin
                            if (w_is_wr) begin
                                r_dirty[w_idx][w_hit_way] <= 1'b1;
                            end
                        end else begin
                            r_idx     <= w_idx;
                            r_way     <= w_vic;
                            r_req_tag <= w_tag;
                            r_beat    <= '0;
                            r_state   <= (r_valid[w_idx][w_vic] && r_dirty[w_idx][w_vic]) ? S_WB : S_LD;
                        end
                    end
                end
                S_WB: begin
                    if (!dwait) begin
                        if (w_last_beat) begin
                            r_dirty[r_idx][r_way] <= 1'b0;
                            r_beat                <= '0;
                            r_state               <= S_LD;
                        end else begin
                            r_beat <= r_beat + BLK_W'(1);
                        end
                    end
                end
                S_LD: begin
                    if (!dwait) begin
                        if (w_last_beat) begin
                            r_tag[r_idx][r_way]   <= r_req_tag;
                            r_valid[r_idx][r_way] <= 1'b1;
                            r_dirty[r_idx][r_way] <= 1'b0;
                            r_beat                <= '0;
                            r_state               <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + BLK_W'(1);
                        end
                    end
                end
                S_SCAN: begin
                    r_idx  <= w_scan_idx;
                    r_way  <= w_scan_way;
                    r_beat <= '0;
                    if (r_valid[w_scan_idx][w_scan_way] && r_dirty[w_scan_idx][w_scan_way]) begin
                        r_state <= S_FLUSH;
                    end else if (w_last_ptr) begin
                        r_state <= S_END;
                    end else begin
                        r_ptr <= r_ptr + PTR_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (!dwait) begin
                        if (w_last_beat) begin
                            r_dirty[r_idx][r_way] <= 1'b0;
                            r_beat                <= '0;
                            if (w_last_ptr) begin
                                r_state <= S_END;
                            end else begin
                                r_ptr   <= r_ptr + PTR_W'(1);
                                r_state <= S_SCAN;
                            end
                        end else begin
                            r_beat <= r_beat + BLK_W'(1);
                        end
                    end
                end
                S_CNT: begin
                    if (!dwait) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge CLK) begin
        if (w_hit_now && w_is_wr) begin
            r_data[w_idx][w_hit_way][w_blk] <= dmemstore;
        end
        if ((r_state == S_LD) && !dwait) begin
            r_data[r_idx][r_way][r_beat] <= dload;
        end
    end

`ifdef HIT_COUNT_EN
    logic [31:0] r_hit_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_cnt <= '0;
        end else if (w_hit_now) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
        end else if (w_miss_now) begin
            r_hit_cnt <= r_hit_cnt - 32'd1;
        end
    end

    assign w_cnt_val = r_hit_cnt;
`else
    assign w_cnt_val = 32'd0;
`endif

    always_comb begin
        dhit     = w_hit_now;
        dmemload = w_hit_now ? r_data[w_idx][w_hit_way][w_blk] : 32'd0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'd0;
        dstore   = 32'd0;
        case (r_state)
            S_WB, S_FLUSH: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[r_idx][r_way], r_idx, r_beat, 2'b00};
                dstore = r_data[r_idx][r_way][r_beat];
            end
            S_LD: begin
                dREN  = 1'b1;
                daddr = {r_req_tag, r_idx, r_beat, 2'b00};
            end
            S_CNT: begin
                dWEN   = 1'b1;
                daddr  = CNT_ADDR;
                dstore = w_cnt_val;
            end
            S_DONE: flushed = 1'b1;
            default: ;
        endcase
    end
endmodule
